sram22_sp_ram_gen: RTL and testbench

- Parametrised, synthesizable behavioural model of a single-port SRAM22 macro: byte-group masked writes, configurable read latency, and a selectable read-during-write output mode.
- Generalises the fixed-geometry macro models.
- Sits behind the SRAM22 macro wrappers and serves as the simulation/FPGA stand-in for any generated geometry.

---
 rtl/sram22_pkg.sv | 28 ++
 rtl/sram22_rd_pipe.sv | 50 +++++
 rtl/sram22_sp_ram_gen.sv | 158 +++++++++++++++
 tb/tb_sram22_sp_ram_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sram22_pkg.sv
// rtl/sram22_pkg.sv - shared constants, clear-FSM state type and mask-merge helper for the SRAM22 model.
package sram22_pkg;

  localparam int RDW_NO_CHANGE   = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_READ_FIRST  = 2;

  // Widest word the merge helper handles; callers zero-extend and slice back.
  localparam int SRAM22_MAX_DW = 1024;

  typedef logic [0:0] clr_state_t;
  localparam clr_state_t ST_CLEAR = 1'b0;
  localparam clr_state_t ST_READY = 1'b1;

  function automatic logic [SRAM22_MAX_DW-1:0] sram22_mask_merge(
    input logic [SRAM22_MAX_DW-1:0] old_word,
    input logic [SRAM22_MAX_DW-1:0] new_word,
    input logic [SRAM22_MAX_DW-1:0] mask,
    input int                       group
  );
    logic [SRAM22_MAX_DW-1:0] res;
    for (int i = 0; i < SRAM22_MAX_DW; i++) begin
      res[i] = mask[i / group] ? new_word[i] : old_word[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram22_rd_pipe.sv
// rtl/sram22_rd_pipe.sv - valid+data shift pipeline that delays read results by DEPTH cycles.
module sram22_rd_pipe #(
  parameter int DEPTH = 0,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic clk_rst_unused;
      assign clk_rst_unused = clk ^ rst_n;
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_pipe
      logic [DEPTH-1:0]         vld_q, vld_d;
      logic [DEPTH-1:0][DW-1:0] data_q, data_d;

      always_comb begin
        vld_d     = vld_q;
        data_d    = data_q;
        vld_d[0]  = in_valid;
        data_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
          vld_d[i]  = vld_q[i-1];
          data_d[i] = data_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q  <= '0;
          data_q <= '0;
        end else begin
          vld_q  <= vld_d;
          data_q <= data_d;
        end
      end

      assign out_valid = vld_q[DEPTH-1];
      assign out_data  = data_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sram22_sp_ram_gen.sv
// rtl/sram22_sp_ram_gen.sv - parametrised single-port SRAM22 model with masked writes and read pipeline.
// Optional power-on clear sequencer enabled by defining SRAM22_INIT_CLEAR_EN.
module sram22_sp_ram_gen
  import sram22_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 9,
  parameter int WMASK_WIDTH = 8,
  parameter int RD_LATENCY  = 1,
  parameter int RDW_MODE    = 0
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   ce,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  output logic                   busy
);

  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int GROUP     = DATA_WIDTH / WMASK_WIDTH;

  generate
    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
      $fatal(1, "sram22_sp_ram_gen: DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
      $fatal(1, "sram22_sp_ram_gen: RD_LATENCY must be 1..4");
    end
    if (RDW_MODE < 0 || RDW_MODE > 2) begin : g_bad_rdw
      $fatal(1, "sram22_sp_ram_gen: RDW_MODE must be 0..2");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic                  busy_w;
  logic                  clr_wr;
  logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef SRAM22_INIT_CLEAR_EN
  clr_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_READY;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_w   = (state_q == ST_CLEAR);
  assign clr_wr   = busy_w;
  assign clr_addr = cnt_q;
`else
  assign busy_w   = 1'b0;
  assign clr_wr   = 1'b0;
  assign clr_addr = '0;
`endif

  logic                     addr_x;
  logic                     acc;
  logic [DATA_WIDTH-1:0]    old_word;
  logic [DATA_WIDTH-1:0]    merged_word;
  logic [SRAM22_MAX_DW-1:0] old_ext, din_ext, mask_ext, merge_wide_unused;
  logic                     pipe_in_valid;
  logic [DATA_WIDTH-1:0]    pipe_in_data;

`ifndef SYNTHESIS
  assign addr_x = $isunknown(addr);
`else
  assign addr_x = 1'b0;
`endif

  always_comb begin
    acc      = ce && !busy_w && !addr_x;
    old_word = mem_q[addr];
    old_ext  = '0;
    din_ext  = '0;
    mask_ext = '0;
    old_ext[DATA_WIDTH-1:0]   = old_word;
    din_ext[DATA_WIDTH-1:0]   = din;
    mask_ext[WMASK_WIDTH-1:0] = wmask;
    merge_wide_unused = sram22_mask_merge(old_ext, din_ext, mask_ext, GROUP);
    merged_word       = merge_wide_unused[DATA_WIDTH-1:0];
    // Reads always enter the pipe; writes only when the RDW mode asks for an echo.
    pipe_in_valid = acc && (!we || RDW_MODE != RDW_NO_CHANGE);
    pipe_in_data  = (we && RDW_MODE == RDW_WRITE_FIRST) ? merged_word : old_word;
  end

  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem_q[clr_addr] <= '0;
    end else if (acc && we) begin
      mem_q[addr] <= merged_word;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (ce && !busy_w && addr_x) $error("sram22_sp_ram_gen: access with unknown addr ignored");
  end
`endif

  logic                  pipe_out_valid;
  logic [DATA_WIDTH-1:0] pipe_out_data;

  sram22_rd_pipe #(
    .DEPTH (RD_LATENCY - 1),
    .DW    (DATA_WIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rstb),
    .in_valid  (pipe_in_valid),
    .in_data   (pipe_in_data),
    .out_valid (pipe_out_valid),
    .out_data  (pipe_out_data)
  );

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;

  always_comb begin
    dout_d       = pipe_out_valid ? pipe_out_data : dout_q;
    dout_valid_d = pipe_out_valid;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_w;

endmodule

// File: tb/tb_sram22_sp_ram_gen.sv
// tb/tb_sram22_sp_ram_gen.sv - directed self-checking bench for sram22_sp_ram_gen across latency and RDW modes.
module tb_sram22_sp_ram_gen;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  wmask = '0;
  logic [8:0]  addr = '0;
  logic [63:0] din = '0;

  logic [63:0] dout0, dout3, doutwf, doutrf;
  logic        dv0, dv3, dvwf, dvrf;
  logic        busy0, busy3, busywf, busyrf;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  sram22_sp_ram_gen #(.RD_LATENCY(1), .RDW_MODE(0)) u_d0 (
    .clk(clk), .rstb(rstb), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
    .dout(dout0), .dout_valid(dv0), .busy(busy0));
  sram22_sp_ram_gen #(.RD_LATENCY(3), .RDW_MODE(0)) u_d3 (
    .clk(clk), .rstb(rstb), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
    .dout(dout3), .dout_valid(dv3), .busy(busy3));
  sram22_sp_ram_gen #(.RD_LATENCY(1), .RDW_MODE(1)) u_wf (
    .clk(clk), .rstb(rstb), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
    .dout(doutwf), .dout_valid(dvwf), .busy(busywf));
  sram22_sp_ram_gen #(.RD_LATENCY(1), .RDW_MODE(2)) u_rf (
    .clk(clk), .rstb(rstb), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
    .dout(doutrf), .dout_valid(dvrf), .busy(busyrf));

`ifdef SRAM22_INIT_CLEAR_EN
  logic [63:0] doutc;
  logic        dvc, busyc;
  sram22_sp_ram_gen #(.ADDR_WIDTH(4)) u_c (
    .clk(clk), .rstb(rstb), .ce(ce), .we(we), .wmask(wmask), .addr(addr[3:0]), .din(din),
    .dout(doutc), .dout_valid(dvc), .busy(busyc));
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic w, input logic [8:0] a, input logic [63:0] d, input logic [7:0] m);
    ce = 1'b1; we = w; addr = a; din = d; wmask = m;
    tick();
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while ((busy0 || busy3 || busywf || busyrf) && n < 1200) begin
      tick();
      n++;
    end
    check("ready_timeout", {63'd0, busy0 | busy3 | busywf | busyrf}, 64'd0);
  endtask

  initial begin
    int pulses;
    logic [63:0] exp10;
    #12;
    check("rst_dout", dout0, 64'd0);
    check("rst_dv", {63'd0, dv0}, 64'd0);
    @(posedge clk); #1;
    rstb = 1'b1;

`ifdef SRAM22_INIT_CLEAR_EN
    begin
      int nb = 0;
      pulses = 0;
      check("clr_busy_start", {63'd0, busyc}, 64'd1);
      ce = 1'b1; we = 1'b0; addr = 9'd3;
      while (busyc && nb < 40) begin
        tick();
        nb++;
        if (dvc) pulses++;
        ce = 1'b0;
      end
      check("clr_busy_len", 64'(nb), 64'd16);
      check("clr_ce_ignored", 64'(pulses), 64'd0);
      for (int i = 0; i < 16; i++) begin
        access(1'b0, 9'(i), 64'd0, 8'd0);
        check("clr_zero_dv", {63'd0, dvc}, 64'd1);
        check("clr_zero", doutc, 64'd0);
      end
      rstb = 1'b0; #2; rstb = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      rstb = 1'b0; #2; rstb = 1'b1;
      nb = 0;
      while (busyc && nb < 40) begin
        tick();
        nb++;
      end
      check("clr_restart_len", 64'(nb), 64'd16);
    end
    wait_ready();
`else
    check("busy_tied0", {63'd0, busy0}, 64'd0);
`endif

    // Masked write then read, default geometry.
    access(1'b1, 9'h1A5, 64'h0123456789ABCDEF, 8'hFF);
    check("nc_wr_nodv", {63'd0, dv0}, 64'd0);
    check("wf_wr1_dv", {63'd0, dvwf}, 64'd1);
    check("wf_wr1_data", doutwf, 64'h0123456789ABCDEF);
    check("rf_wr1_dv", {63'd0, dvrf}, 64'd1);
    access(1'b1, 9'h1A5, 64'hFFFFFFFFFFFFFFFF, 8'h81);
    check("wf_wr2_data", doutwf, 64'hFF23456789ABCDFF);
    check("rf_wr2_data", doutrf, 64'h0123456789ABCDEF);
    access(1'b0, 9'h1A5, 64'd0, 8'd0);
    check("mask_rd_dv", {63'd0, dv0}, 64'd1);
    check("mask_rd_data", dout0, 64'hFF23456789ABCDFF);
    tick();
    check("mask_rd_dv_once", {63'd0, dv0}, 64'd0);
    check("mask_rd_hold", dout0, 64'hFF23456789ABCDFF);

    // Read-during-write modes.
    access(1'b1, 9'd5, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
    access(1'b1, 9'd5, 64'h5555555555555555, 8'h0F);
    check("wf_rdw_dv", {63'd0, dvwf}, 64'd1);
    check("wf_rdw_data", doutwf, 64'hAAAAAAAA55555555);
    check("rf_rdw_dv", {63'd0, dvrf}, 64'd1);
    check("rf_rdw_data", doutrf, 64'hAAAAAAAAAAAAAAAA);
    check("nc_rdw_dv", {63'd0, dv0}, 64'd0);
    check("nc_rdw_hold", dout0, 64'hFF23456789ABCDFF);
    access(1'b0, 9'd5, 64'd0, 8'd0);
    check("b2b_rd_new", dout0, 64'hAAAAAAAA55555555);
    access(1'b1, 9'd5, 64'h0, 8'h00);
    check("wf_mask0_dv", {63'd0, dvwf}, 64'd1);
    check("wf_mask0_data", doutwf, 64'hAAAAAAAA55555555);

    // Latency 3 streaming reads.
    access(1'b1, 9'd0, 64'h00000000000000A0, 8'hFF);
    access(1'b1, 9'd1, 64'h00000000000000A1, 8'hFF);
    access(1'b1, 9'd2, 64'h00000000000000A2, 8'hFF);
    check("l3_wr_nodv", {63'd0, dv3}, 64'd0);
    access(1'b0, 9'd0, 64'd0, 8'd0);
    check("l3_e1_dv", {63'd0, dv3}, 64'd0);
    access(1'b0, 9'd1, 64'd0, 8'd0);
    check("l3_e2_dv", {63'd0, dv3}, 64'd0);
    access(1'b0, 9'd2, 64'd0, 8'd0);
    check("l3_e3_dv", {63'd0, dv3}, 64'd1);
    check("l3_e3_data", dout3, 64'hA0);
    tick();
    check("l3_e4_dv", {63'd0, dv3}, 64'd1);
    check("l3_e4_data", dout3, 64'hA1);
    tick();
    check("l3_e5_dv", {63'd0, dv3}, 64'd1);
    check("l3_e5_data", dout3, 64'hA2);
    tick();
    check("l3_e6_dv", {63'd0, dv3}, 64'd0);
    check("l3_e6_hold", dout3, 64'hA2);

    // Reset with two reads in flight.
    access(1'b1, 9'h10, 64'h1010101010101010, 8'hFF);
    access(1'b0, 9'd0, 64'd0, 8'd0);
    access(1'b0, 9'd1, 64'd0, 8'd0);
    rstb = 1'b0;
    #1;
    check("rst_fl_dout", dout3, 64'd0);
    check("rst_fl_dv", {63'd0, dv3}, 64'd0);
    tick();
    tick();
    rstb = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dv3) pulses++;
    end
    check("rst_fl_nopulse", 64'(pulses), 64'd0);
`ifdef SRAM22_INIT_CLEAR_EN
    wait_ready();
    exp10 = 64'd0;
`else
    exp10 = 64'h1010101010101010;
`endif
    access(1'b0, 9'h10, 64'd0, 8'd0);
    check("rst_rd0_data", dout0, exp10);
    tick();
    tick();
    check("rst_rd3_dv", {63'd0, dv3}, 64'd1);
    check("rst_rd3_data", dout3, exp10);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
